jtag_dr_responder: RTL and testbench

- User-side responder for the 9-bit-IR virtual JTAG hub port.
- Consumes `tdi`, `ir_in` and the `virtual_state_*` strobes; drives `tdo` and `ir_out`.
- Decodes the instruction and implements the selected data register: bypass, ID, write-to-fabric, read-from-fabric or status.
- Bridges JTAG DR scans to valid/ready word handshakes toward the application logic, all in the `tck` domain.

---
 rtl/jtag_dr_responder.sv | 203 ++++++++++++++++++++
 tb/tb_jtag_dr_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dr_responder.sv
// User-side data-register responder behind a 9-bit-IR virtual JTAG hub port, bridging DR scans to word handshakes.
// Optional scan-length checking on update is enabled by defining JTAG_DR_LEN_CHECK_EN.
module jtag_dr_responder #(
    parameter int                IR_W     = 9,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] ID_VALUE = 32'h4A54_4147
) (
    input  logic              tck,
    input  logic              rst,
    input  logic              tdi,
    output logic              tdo,
    input  logic [IR_W-1:0]   ir_in,
    output logic [IR_W-1:0]   ir_out,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_e1dr,
    input  logic              virtual_state_pdr,
    input  logic              virtual_state_e2dr,
    input  logic              virtual_state_udr,
    input  logic              virtual_state_cir,
    input  logic              virtual_state_uir,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    output logic [1:0]        dbg_state_o
);

    localparam int CNT_W = $clog2(DATA_W + 2);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHIFT, S_PAUSE} state_t;
    typedef enum logic [2:0] {DR_BYPASS, DR_ID, DR_WRITE, DR_READ, DR_STATUS} dr_sel_t;

    function automatic dr_sel_t decode(input logic [IR_W-1:0] ir);
        dr_sel_t sel;
        sel = DR_BYPASS;
        if (ir == IR_W'(1)) sel = DR_ID;
        else if (ir == IR_W'(2)) sel = DR_WRITE;
        else if (ir == IR_W'(3)) sel = DR_READ;
        else if (ir == IR_W'(4)) sel = DR_STATUS;
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] dr_len(input dr_sel_t sel);
        logic [CNT_W-1:0] len;
        case (sel)
            DR_BYPASS: len = CNT_W'(1);
            DR_STATUS: len = CNT_W'(8);
            default:   len = CNT_W'(DATA_W);
        endcase
        return len;
    endfunction

    state_t            state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_valid_q, wr_valid_d;
    logic              short_err_q, short_err_d;
    logic              underflow_q, underflow_d;
    logic              overflow_q, overflow_d;
    logic [IR_W-1:0]   ir_out_q, ir_out_d;

    dr_sel_t          cap_sel, cur_sel;
    logic [CNT_W-1:0] cur_len;
    logic             in_scan, do_capture, do_shift, do_update, len_ok, commit;
    logic             wr_fire, wr_commit, status_clr;
    logic             short_set, underflow_set, overflow_set;
    logic             rd_pop;

    // State register
    always_ff @(posedge tck) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; cir aborts any scan, cdr (re)arms from any state
    always_comb begin
        state_d = state_q;
        if (virtual_state_cir) begin
            state_d = S_IDLE;
        end else if (virtual_state_cdr) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (virtual_state_udr)      state_d = S_IDLE;
                    else if (virtual_state_sdr) state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    if (virtual_state_udr) state_d = S_IDLE;
                    else if (virtual_state_e1dr || virtual_state_pdr || virtual_state_e2dr)
                        state_d = S_PAUSE;
                end
                S_PAUSE: begin
                    if (virtual_state_udr)      state_d = S_IDLE;
                    else if (virtual_state_sdr) state_d = S_SHIFT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output and datapath next-state logic
    always_comb begin
        cap_sel    = decode(ir_in);
        cur_sel    = decode(ir_q);
        cur_len    = dr_len(cur_sel);
        in_scan    = (state_q != S_IDLE);
        do_capture = virtual_state_cdr && !virtual_state_cir;
        do_shift   = virtual_state_sdr && in_scan && !virtual_state_cir && !virtual_state_cdr;
        do_update  = virtual_state_udr && in_scan && !virtual_state_cir && !virtual_state_cdr;
`ifdef JTAG_DR_LEN_CHECK_EN
        len_ok     = (cnt_q == cur_len);
        short_set  = do_update && !len_ok;
`else
        len_ok     = 1'b1;
        short_set  = 1'b0;
`endif
        commit        = do_update && len_ok;
        rd_pop        = do_capture && (cap_sel == DR_READ) && rd_valid;
        underflow_set = do_capture && (cap_sel == DR_READ) && !rd_valid;

        ir_d = ir_q;
        if (virtual_state_cir || virtual_state_uir || virtual_state_cdr) ir_d = ir_in;

        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (do_capture) begin
            cnt_d = '0;
            case (cap_sel)
                DR_ID:   sr_d = ID_VALUE;
                DR_READ: sr_d = rd_valid ? rd_data : '0;
                DR_STATUS: begin
                    sr_d      = '0;
                    sr_d[7:0] = {3'b000, short_err_q, underflow_q, overflow_q, rd_valid, wr_valid_q};
                end
                default: sr_d = '0;
            endcase
        end else if (do_shift) begin
            if (cnt_q != cur_len + CNT_W'(1)) cnt_d = cnt_q + CNT_W'(1);
            case (cur_sel)
                DR_BYPASS: sr_d[0]   = tdi;
                DR_STATUS: sr_d[7:0] = {tdi, sr_q[7:1]};
                default:   sr_d      = {tdi, sr_q[DATA_W-1:1]};
            endcase
        end

        // A same-cycle handshake frees the slot, so the new word loads without overflow
        wr_fire      = wr_valid_q && wr_ready;
        wr_commit    = commit && (cur_sel == DR_WRITE);
        overflow_set = wr_commit && wr_valid_q && !wr_ready;
        wr_valid_d   = wr_valid_q && !wr_fire;
        wr_data_d    = wr_data_q;
        if (wr_commit && (!wr_valid_q || wr_ready)) begin
            wr_data_d  = sr_q;
            wr_valid_d = 1'b1;
        end

        status_clr  = commit && (cur_sel == DR_STATUS);
        short_err_d = (short_err_q && !(status_clr && sr_q[4])) || short_set;
        underflow_d = (underflow_q && !(status_clr && sr_q[3])) || underflow_set;
        overflow_d  = (overflow_q  && !(status_clr && sr_q[2])) || overflow_set;

        ir_out_d      = '0;
        ir_out_d[4:0] = {short_err_q, underflow_q, overflow_q, rd_valid, wr_valid_q};

        tdo         = sr_q[0];
        rd_ready    = rd_pop && !rst;
        wr_data     = wr_data_q;
        wr_valid    = wr_valid_q;
        ir_out      = ir_out_q;
        dbg_state_o = state_q;
    end

    always_ff @(posedge tck) begin
        if (rst) begin
            ir_q        <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            wr_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            short_err_q <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            ir_out_q    <= '0;
        end else begin
            ir_q        <= ir_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            wr_data_q   <= wr_data_d;
            wr_valid_q  <= wr_valid_d;
            short_err_q <= short_err_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            ir_out_q    <= ir_out_d;
        end
    end

endmodule

// File: tb/tb_jtag_dr_responder.sv
// Directed bench for jtag_dr_responder: drives TAP strobes, checks tdo streams, handshakes and flags.
module tb_jtag_dr_responder;

    logic        tck = 1'b0;
    logic        rst, tdi;
    logic        tdo;
    logic [8:0]  ir_in, ir_out;
    logic        vs_cdr, vs_sdr, vs_e1dr, vs_pdr, vs_e2dr, vs_udr, vs_cir, vs_uir;
    logic [31:0] wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, rd_ready;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    jtag_dr_responder dut (
        .tck(tck), .rst(rst), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out),
        .virtual_state_cdr(vs_cdr), .virtual_state_sdr(vs_sdr),
        .virtual_state_e1dr(vs_e1dr), .virtual_state_pdr(vs_pdr),
        .virtual_state_e2dr(vs_e2dr), .virtual_state_udr(vs_udr),
        .virtual_state_cir(vs_cir), .virtual_state_uir(vs_uir),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .dbg_state_o(dbg_state)
    );

    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge tck);
        #1;
    endtask

    task automatic scan_ir(input logic [8:0] code);
        ir_in  = code;
        vs_cir = 1'b1;
        cycle();
        vs_cir = 1'b0;
        vs_uir = 1'b1;
        cycle();
        vs_uir = 1'b0;
    endtask

    task automatic dr_scan(input logic [31:0] din, input int nshift, input logic rdy_at_udr,
                           output logic [31:0] dout, output int pops);
        dout   = '0;
        pops   = 0;
        vs_cdr = 1'b1;
        #1;
        if (rd_ready) pops++;
        cycle();
        vs_cdr = 1'b0;
        for (int i = 0; i < nshift; i++) begin
            vs_sdr = 1'b1;
            tdi    = din[i];
            #1;
            dout[i] = tdo;
            if (rd_ready) pops++;
            cycle();
        end
        vs_sdr  = 1'b0;
        tdi     = 1'b0;
        vs_e1dr = 1'b1;
        cycle();
        vs_e1dr  = 1'b0;
        vs_udr   = 1'b1;
        wr_ready = rdy_at_udr;
        cycle();
        vs_udr   = 1'b0;
        wr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        checks++; if (tdo !== 1'b0) begin failures++; $display("FAIL reset_tdo: got %b want 0", tdo); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
        checks++; if (wr_data !== 32'h0) begin failures++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        checks++; if (rd_ready !== 1'b0) begin failures++; $display("FAIL reset_rd_ready: got %b want 0", rd_ready); end
        checks++; if (ir_out !== 9'h000) begin failures++; $display("FAIL reset_ir_out: got %h want 000", ir_out); end
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_id();
        logic [31:0] dout;
        int pops;
        scan_ir(9'h001);
        dr_scan(32'h0, 32, 1'b0, dout, pops);
        checks++; if (dout !== 32'h4A54_4147) begin failures++; $display("FAIL id_tdo: got %h want 4a544147", dout); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL id_wr_valid: got %b want 0", wr_valid); end
    endtask

    task automatic test_write_overflow();
        logic [31:0] dout;
        int pops;
        scan_ir(9'h002);
        dr_scan(32'hDEAD_BEEF, 32, 1'b0, dout, pops);
        checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL wr1_valid: got %b want 1", wr_valid); end
        checks++; if (wr_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr1_data: got %h want deadbeef", wr_data); end
        dr_scan(32'h1234_5678, 32, 1'b0, dout, pops);
        checks++; if (wr_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr2_data_kept: got %h want deadbeef", wr_data); end
        cycle();
        checks++; if (ir_out !== 9'h005) begin failures++; $display("FAIL wr2_ir_out: got %h want 005", ir_out); end
        wr_ready = 1'b1;
        cycle();
        wr_ready = 1'b0;
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL wr_drain_valid: got %b want 0", wr_valid); end
    endtask

    task automatic test_status_clear();
        logic [31:0] dout;
        int pops;
        scan_ir(9'h004);
        dr_scan(32'h0000_001C, 8, 1'b0, dout, pops);
        checks++; if (dout[7:0] !== 8'h04) begin failures++; $display("FAIL status_capture: got %h want 04", dout[7:0]); end
        cycle();
        checks++; if (ir_out !== 9'h000) begin failures++; $display("FAIL status_cleared_ir_out: got %h want 000", ir_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] dout;
        int pops;
        scan_ir(9'h002);
        dr_scan(32'hA5A5_0001, 32, 1'b0, dout, pops);
        dr_scan(32'h5A5A_0002, 32, 1'b1, dout, pops);
        checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %b want 1", wr_valid); end
        checks++; if (wr_data !== 32'h5A5A_0002) begin failures++; $display("FAIL b2b_data: got %h want 5a5a0002", wr_data); end
        cycle();
        checks++; if (ir_out !== 9'h001) begin failures++; $display("FAIL b2b_ir_out: got %h want 001", ir_out); end
        wr_ready = 1'b1;
        cycle();
        wr_ready = 1'b0;
    endtask

    task automatic test_read();
        logic [31:0] dout;
        int pops;
        rd_data  = 32'hCAFE_0001;
        rd_valid = 1'b1;
        scan_ir(9'h003);
        checks++; if (ir_out !== 9'h002) begin failures++; $display("FAIL rd_avail_ir_out: got %h want 002", ir_out); end
        dr_scan(32'h0, 32, 1'b0, dout, pops);
        checks++; if (pops !== 1) begin failures++; $display("FAIL rd_pop_count: got %0d want 1", pops); end
        checks++; if (dout !== 32'hCAFE_0001) begin failures++; $display("FAIL rd_tdo: got %h want cafe0001", dout); end
        rd_valid = 1'b0;
        rd_data  = 32'h0;
        dr_scan(32'h0, 32, 1'b0, dout, pops);
        checks++; if (pops !== 0) begin failures++; $display("FAIL rd_empty_pops: got %0d want 0", pops); end
        checks++; if (dout !== 32'h0) begin failures++; $display("FAIL rd_empty_tdo: got %h want 0", dout); end
        cycle();
        checks++; if (ir_out !== 9'h008) begin failures++; $display("FAIL underflow_ir_out: got %h want 008", ir_out); end
    endtask

    task automatic test_short_scan();
        logic [31:0] dout;
        int pops;
        scan_ir(9'h002);
        dr_scan(32'h1234_5678, 31, 1'b0, dout, pops);
`ifdef JTAG_DR_LEN_CHECK_EN
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL short_wr_valid: got %b want 0", wr_valid); end
        cycle();
        checks++; if (ir_out !== 9'h018) begin failures++; $display("FAIL short_ir_out: got %h want 018", ir_out); end
`else
        checks++; if (wr_data !== 32'h2468_ACF0) begin failures++; $display("FAIL short_wr_data: got %h want 2468acf0", wr_data); end
        checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL short_wr_valid: got %b want 1", wr_valid); end
        wr_ready = 1'b1;
        cycle();
        wr_ready = 1'b0;
`endif
        scan_ir(9'h004);
        dr_scan(32'h0000_0010, 8, 1'b0, dout, pops);
`ifdef JTAG_DR_LEN_CHECK_EN
        checks++; if (dout[7:0] !== 8'h18) begin failures++; $display("FAIL short_status_capture: got %h want 18", dout[7:0]); end
`else
        checks++; if (dout[7:0] !== 8'h08) begin failures++; $display("FAIL short_status_capture: got %h want 08", dout[7:0]); end
`endif
        cycle();
        checks++; if (ir_out !== 9'h008) begin failures++; $display("FAIL short_cleared_ir_out: got %h want 008", ir_out); end
    endtask

    task automatic test_bypass();
        logic [31:0] dout;
        int pops;
        scan_ir(9'h1FF);
        dr_scan(32'h0000_000B, 4, 1'b0, dout, pops);
        checks++; if (dout[3:0] !== 4'h6) begin failures++; $display("FAIL bypass_tdo: got %h want 6", dout[3:0]); end
    endtask

    task automatic test_reset_mid_scan();
        scan_ir(9'h002);
        vs_cdr = 1'b1;
        cycle();
        vs_cdr = 1'b0;
        vs_sdr = 1'b1;
        tdi    = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b1;
        cycle();
        rst    = 1'b0;
        vs_sdr = 1'b0;
        tdi    = 1'b0;
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
        checks++; if (tdo !== 1'b0) begin failures++; $display("FAIL midrst_tdo: got %b want 0", tdo); end
        vs_udr = 1'b1;
        cycle();
        vs_udr = 1'b0;
        cycle();
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL midrst_wr_valid: got %b want 0", wr_valid); end
        checks++; if (wr_data !== 32'h0) begin failures++; $display("FAIL midrst_wr_data: got %h want 0", wr_data); end
    endtask

    initial begin
        rst = 1'b0; tdi = 1'b0; ir_in = '0;
        vs_cdr = 1'b0; vs_sdr = 1'b0; vs_e1dr = 1'b0; vs_pdr = 1'b0;
        vs_e2dr = 1'b0; vs_udr = 1'b0; vs_cir = 1'b0; vs_uir = 1'b0;
        wr_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        test_reset();
        test_id();
        test_write_overflow();
        test_status_clear();
        test_back_to_back();
        test_read();
        test_short_scan();
        test_bypass();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
